// File: rtl/hcpu_pkg.sv
// Shared decode constants and FSM state encoding for the stalling Hack CPU.
package hcpu_pkg;

  // Instruction field positions
  localparam int unsigned InstrTypeBit = 15;
  localparam int unsigned ABit         = 12;
  localparam int unsigned CompHi       = 11;
  localparam int unsigned CompLo       = 6;
  localparam int unsigned DestABit     = 5;
  localparam int unsigned DestDBit     = 4;
  localparam int unsigned DestMBit     = 3;
  localparam int unsigned JumpHi       = 2;
  localparam int unsigned JumpLo       = 0;

  // Jump codes (j1 = less-than, j2 = equal, j3 = greater-than)
  localparam logic [2:0] JmpNull = 3'b000;
  localparam logic [2:0] JmpJgt  = 3'b001;
  localparam logic [2:0] JmpJeq  = 3'b010;
  localparam logic [2:0] JmpJge  = 3'b011;
  localparam logic [2:0] JmpJlt  = 3'b100;
  localparam logic [2:0] JmpJne  = 3'b101;
  localparam logic [2:0] JmpJle  = 3'b110;
  localparam logic [2:0] JmpJmp  = 3'b111;

  typedef enum logic [1:0] {
    StExec = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2
  } state_e;

  // Signed compare of the ALU result against zero, selected by the jump code
  function automatic logic jump_taken(input logic [2:0] jump, input logic zr, input logic ng);
    logic lt, eq, gt;
    lt = ng;
    eq = zr;
    gt = ~ng & ~zr;
    return (jump[2] & lt) | (jump[1] & eq) | (jump[0] & gt);
  endfunction

endpackage

// File: rtl/hack_alu_w.sv
// Hack ALU widened to WIDTH bits: zx/nx/zy/ny/f/no with zero and negative flags.
module hack_alu_w #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [5:0]       comp_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zr_o,
  output logic             ng_o
);

  logic [WIDTH-1:0] xz, xn, yz, yn, fo;

  // Operand conditioning, function select and optional output negation
  always_comb begin
    xz       = comp_i[5] ? '0 : x_i;
    xn       = comp_i[4] ? ~xz : xz;
    yz       = comp_i[3] ? '0 : y_i;
    yn       = comp_i[2] ? ~yz : yz;
    fo       = comp_i[1] ? (xn + yn) : (xn & yn);
    result_o = comp_i[0] ? ~fo : fo;
    zr_o     = (result_o == '0);
    ng_o     = result_o[WIDTH-1];
  end

endmodule

// File: rtl/hcpu_stall.sv
// Hack CPU with valid/ready handshakes on fetch and data memory. Register-only
// instructions commit in one cycle; M reads and writes stall in RD/WR until
// mem_ready.
module hcpu_stall
  import hcpu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned PC_W   = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ack,
  input  logic [WIDTH-1:0]  inM,
  input  logic              mem_ready,
  output logic              readM,
  output logic              writeM,
  output logic [WIDTH-1:0]  outM,
  output logic [ADDR_W-1:0] addressM,
  output logic [PC_W-1:0]   pc
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              readM_q, readM_d;
  logic              writeM_q, writeM_d;
  logic [WIDTH-1:0]  outM_q, outM_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic             isC, aSel, destA, destD, destM;
  logic [5:0]       comp;
  logic [2:0]       jump;
  logic [WIDTH-1:0] aluY, aluOut, aImm;
  logic             zr, ng, commit;

  assign isC   = instruction[InstrTypeBit];
  assign aSel  = instruction[ABit];
  assign comp  = instruction[CompHi:CompLo];
  assign destA = instruction[DestABit];
  assign destD = instruction[DestDBit];
  assign destM = instruction[DestMBit];
  assign jump  = instruction[JumpHi:JumpLo];
  assign aImm  = {{(WIDTH-15){1'b0}}, instruction[14:0]};
  // inM only matters in RD, where the a=1 instruction is being completed
  assign aluY  = aSel ? inM : a_q;

  hack_alu_w #(
    .WIDTH(WIDTH)
  ) u_alu (
    .x_i     (d_q),
    .y_i     (aluY),
    .comp_i  (comp),
    .result_o(aluOut),
    .zr_o    (zr),
    .ng_o    (ng)
  );

  // Next-state: FSM transitions, memory requests and instruction commit
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    d_d       = d_q;
    pc_d      = pc_q;
    readM_d   = readM_q;
    writeM_d  = writeM_q;
    outM_d    = outM_q;
    addr_d    = addr_q;
    commit    = 1'b0;

    unique case (state_q)
      StExec: begin
        if (instr_valid) begin
          if (!isC) begin
            commit = 1'b1;
          end else if (!aSel) begin
            commit = 1'b1;
            if (destM) begin
              // Address comes from A before any A-dest update of this instruction
              addr_d   = a_q[ADDR_W-1:0];
              outM_d   = aluOut;
              writeM_d = 1'b1;
              state_d  = StWr;
            end
          end else begin
            addr_d  = a_q[ADDR_W-1:0];
            readM_d = 1'b1;
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (mem_ready) begin
          commit  = 1'b1;
          readM_d = 1'b0;
          if (destM) begin
            outM_d   = aluOut;
            writeM_d = 1'b1;
            state_d  = StWr;
          end else begin
            state_d = StExec;
          end
        end
      end
      StWr: begin
        if (mem_ready) begin
          writeM_d = 1'b0;
          state_d  = StExec;
        end
      end
      default: state_d = StExec;
    endcase

    if (commit) begin
      if (!isC) begin
        a_d = aImm;
      end else begin
        if (destA) a_d = aluOut;
        if (destD) d_d = aluOut;
      end
      if (isC && jump_taken(jump, zr, ng)) pc_d = a_q[PC_W-1:0];
      else                                  pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  // Commit strobe: depends only on state, fetch valid, decode and memory ready
  always_comb begin
    instr_ack = 1'b0;
    unique case (state_q)
      StExec:  instr_ack = instr_valid & ~(isC & aSel);
      StRd:    instr_ack = mem_ready;
      default: instr_ack = 1'b0;
    endcase
  end

  // State registers; reset abandons any in-flight access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StExec;
      a_q      <= '0;
      d_q      <= '0;
      pc_q     <= '0;
      readM_q  <= 1'b0;
      writeM_q <= 1'b0;
      outM_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      pc_q     <= pc_d;
      readM_q  <= readM_d;
      writeM_q <= writeM_d;
      outM_q   <= outM_d;
      addr_q   <= addr_d;
    end
  end

  assign readM    = readM_q;
  assign writeM   = writeM_q;
  assign outM     = outM_q;
  assign addressM = addr_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_hcpu_stall.sv
// Directed bench for hcpu_stall: a 16-bit instance for most scenarios and a
// 32-bit instance for the widened datapath.
module tb_hcpu_stall;

  logic        clock;
  logic        reset;

  logic [15:0] instruction;
  logic        instrValid;
  logic        instrAck;
  logic [15:0] inM;
  logic        memReady;
  logic        readM;
  logic        writeM;
  logic [15:0] outM;
  logic [14:0] addressM;
  logic [14:0] pc;

  logic [15:0] instr32;
  logic        valid32;
  logic        ack32;
  logic [31:0] inM32;
  logic        ready32;
  logic        readM32;
  logic        writeM32;
  logic [31:0] outM32;
  logic [14:0] addr32;
  logic [14:0] pc32;

  int checks = 0;
  int errors = 0;

  hcpu_stall #(
    .WIDTH (16),
    .ADDR_W(15),
    .PC_W  (15)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .instruction(instruction),
    .instr_valid(instrValid),
    .instr_ack  (instrAck),
    .inM        (inM),
    .mem_ready  (memReady),
    .readM      (readM),
    .writeM     (writeM),
    .outM       (outM),
    .addressM   (addressM),
    .pc         (pc)
  );

  hcpu_stall #(
    .WIDTH (32),
    .ADDR_W(15),
    .PC_W  (15)
  ) dut32 (
    .clock      (clock),
    .reset      (reset),
    .instruction(instr32),
    .instr_valid(valid32),
    .instr_ack  (ack32),
    .inM        (inM32),
    .mem_ready  (ready32),
    .readM      (readM32),
    .writeM     (writeM32),
    .outM       (outM32),
    .addressM   (addr32),
    .pc         (pc32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 16'h0000;
    instrValid  = 1'b0;
    inM         = 16'h0000;
    memReady    = 1'b0;
    instr32     = 16'h0000;
    valid32     = 1'b0;
    inM32       = 32'h0;
    ready32     = 1'b0;

    // 1. Reset and idle
    tick();
    tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ack", 32'(instrAck), 32'h0);
    chk("rst_readM", 32'(readM), 32'h0);
    chk("rst_writeM", 32'(writeM), 32'h0);
    chk("rst_outM", 32'(outM), 32'h0);
    chk("rst_addr", 32'(addressM), 32'h0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_pc", 32'(pc), 32'h0);
    chk("idle_ack", 32'(instrAck), 32'h0);
    chk("idle_rw", 32'({readM, writeM}), 32'h0);

    // 2. Register ops: A=5, D=A
    memReady    = 1'b1;
    instrValid  = 1'b1;
    instruction = 16'h0005;
    #1 chk("ainst_ack", 32'(instrAck), 32'h1);
    tick();
    chk("ainst_pc", 32'(pc), 32'h1);
    instruction = 16'hEC10;
    #1 chk("dea_ack", 32'(instrAck), 32'h1);
    tick();
    chk("dea_pc", 32'(pc), 32'h2);
    chk("dea_rw", 32'({readM, writeM}), 32'h0);

    // 3. M=D at A=0x10 with two wait cycles
    instruction = 16'h0010;
    tick();
    chk("a10_pc", 32'(pc), 32'h3);
    instruction = 16'hE308;
    memReady    = 1'b0;
    #1 chk("mwr_ack", 32'(instrAck), 32'h1);
    tick();
    chk("mwr_pc", 32'(pc), 32'h4);
    chk("mwr_wr1", 32'(writeM), 32'h1);
    chk("mwr_outM", 32'(outM), 32'h5);
    chk("mwr_addr", 32'(addressM), 32'h10);
    instruction = 16'h0000;
    #1 chk("mwr_noack1", 32'(instrAck), 32'h0);
    tick();
    chk("mwr_wr2", 32'(writeM), 32'h1);
    tick();
    memReady = 1'b1;
    chk("mwr_wr3", 32'(writeM), 32'h1);
    #1 chk("mwr_noack3", 32'(instrAck), 32'h0);
    chk("mwr_hold_out", 32'(outM), 32'h5);
    tick();
    chk("mwr_done", 32'(writeM), 32'h0);
    chk("mwr_next_ack", 32'(instrAck), 32'h1);
    chk("mwr_pc_held", 32'(pc), 32'h4);
    tick();
    chk("a0_pc", 32'(pc), 32'h5);

    // 4. Read-modify-write M=M+1 at A=0x20, inM=0x7FFF, one wait
    instruction = 16'h0020;
    tick();
    instruction = 16'hFDC8;
    inM         = 16'h7FFF;
    memReady    = 1'b0;
    #1 chk("rmw_exec_noack", 32'(instrAck), 32'h0);
    tick();
    chk("rmw_rd1", 32'(readM), 32'h1);
    chk("rmw_addr", 32'(addressM), 32'h20);
    chk("rmw_pc_stall", 32'(pc), 32'h6);
    chk("rmw_rd_noack", 32'(instrAck), 32'h0);
    tick();
    chk("rmw_rd2", 32'(readM), 32'h1);
    memReady = 1'b1;
    #1 chk("rmw_rd_ack", 32'(instrAck), 32'h1);
    tick();
    chk("rmw_rd_off", 32'(readM), 32'h0);
    chk("rmw_wr", 32'(writeM), 32'h1);
    chk("rmw_outM", 32'(outM), 32'h8000);
    chk("rmw_waddr", 32'(addressM), 32'h20);
    chk("rmw_pc", 32'(pc), 32'h7);
    chk("rmw_wr_noack", 32'(instrAck), 32'h0);
    tick();
    chk("rmw_wr_done", 32'(writeM), 32'h0);

    // 5. Jumps and pc wrap
    instruction = 16'hEE90;  // D=-1
    tick();
    instruction = 16'h0020;
    tick();
    chk("j_pre_pc", 32'(pc), 32'h9);
    instruction = 16'hE304;  // D;JLT
    tick();
    chk("jlt_taken", 32'(pc), 32'h20);
    instruction = 16'hEA90;  // D=0
    tick();
    instruction = 16'h0020;
    tick();
    instruction = 16'hE304;
    tick();
    chk("jlt_not", 32'(pc), 32'h23);
    instruction = 16'h7FFF;
    tick();
    instruction = 16'hE307;  // D;JMP
    tick();
    chk("jmp_top", 32'(pc), 32'h7FFF);
    instruction = 16'h0001;
    tick();
    chk("pc_wrap", 32'(pc), 32'h0);

    // 6. Reset while in WR
    instruction = 16'hE308;
    memReady    = 1'b0;
    tick();
    chk("rw_in_wr", 32'(writeM), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rw_async_wr", 32'(writeM), 32'h0);
    chk("rw_async_pc", 32'(pc), 32'h0);
    chk("rw_async_addr", 32'(addressM), 32'h0);
    instrValid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rw_after_ack", 32'(instrAck), 32'h0);

    // 6b. 32-bit datapath: D=-1, M=D, then D;JLT
    valid32 = 1'b1;
    ready32 = 1'b1;
    instr32 = 16'hEE90;
    tick();
    instr32 = 16'h0030;
    tick();
    instr32 = 16'hE308;
    tick();
    chk("w32_outM", outM32, 32'hFFFF_FFFF);
    chk("w32_wr", 32'(writeM32), 32'h1);
    chk("w32_addr", 32'(addr32), 32'h30);
    tick();
    instr32 = 16'h0040;
    tick();
    chk("w32_pc", 32'(pc32), 32'h4);
    instr32 = 16'hE304;
    tick();
    chk("w32_jlt", 32'(pc32), 32'h40);
    valid32 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hcpu_stall.md
Name: hcpu_stall

Overview:
Parametrised successor of the single-cycle Hack CPU. It executes the same 16-bit Hack instruction set on a WIDTH-bit datapath. It adds valid/ready handshakes on instruction fetch and data memory, so ROM and RAM may take any number of cycles. It sits between the instruction ROM and the data RAM/MMIO bus in the computer top level.

Parameters:
WIDTH, 16, datapath width of A, D, ALU, inM and outM; minimum 16.
ADDR_W, 15, data address width; addressM = A[ADDR_W-1:0].
PC_W, 15, program counter width; PC wraps modulo 2^PC_W.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
instruction  in  16  Hack instruction at address pc.
instr_valid  in  1  instruction is valid.
instr_ack  out  1  instruction committed this cycle; pc changes at this edge.
inM  in  WIDTH  read data, sampled when readM && mem_ready.
mem_ready  in  1  memory completes the pending read/write this cycle.
readM  out  1  read request, held until mem_ready.
writeM  out  1  write request, held until mem_ready.
outM  out  WIDTH  write data, registered.
addressM  out  ADDR_W  access address, registered.
pc  out  PC_W  current fetch address.

Behaviour:
- Reset (reset=0, async): A=D=0, pc=0, state=EXEC, readM=writeM=0, outM=0, addressM=0, instr_ack=0. A reset during RD or WR abandons the access; no partial commit.
- Decode: bit15=0 is an A-instruction, A <= zero-extended instruction[14:0]. bit15=1 is a C-instruction: a=bit12, comp=[11:6], dest A/D/M=[5:3], jump=[2:0]. Bits 14:13 are ignored.
- ALU: Hack zx/nx/zy/ny/f/no generalised to WIDTH. The y operand is M when a=1, else A. Add wraps modulo 2^WIDTH. zr/ng are taken on the WIDTH-bit result; jump compares are signed.
- States: EXEC, RD, WR.
- EXEC, instr_valid=0: hold all state; instr_ack=0.
- EXEC, A-instr or C-instr with a=0 and no M dest: commit in one cycle. Update A/D, load pc with A if the jump condition holds else pc+1, instr_ack=1.
- EXEC, C-instr with a=0 and M dest: commit as above. Also addressM <= old A, outM <= ALU result, writeM <= 1, go to WR.
- EXEC, C-instr with a=1: addressM <= A, readM <= 1, go to RD. No commit, instr_ack=0.
- RD: wait while mem_ready=0. On mem_ready=1: compute with inM, commit (instr_ack=1), readM <= 0. If M dest: outM <= result, writeM <= 1, go to WR (same address). Else go to EXEC.
- WR: writeM held; outM and addressM stable. On mem_ready=1: writeM <= 0, go to EXEC. No instruction is accepted while in WR.
- Instruction stability: instruction and instr_valid must stay stable from acceptance until instr_ack.
- Write ordering: when A is both dest and address, the write uses the pre-instruction A.
- Latency: register-only instruction 1 cycle; M write 1 + (≥1) cycles; M read 1 + (≥1) cycles; read-modify-write ≥3 cycles.
- pc wrap: pc = 2^PC_W-1, no jump, gives pc = 0.
- instr_ack is combinational from state, instr_valid and mem_ready.

Decomposition:
- Package hcpu_pkg: instruction bit-position constants, jump code constants, state encoding (EXEC/RD/WR).
- Sub-module hack_alu_w (WIDTH-parametrised combinational ALU with zr/ng outputs). FSM, registers and PC remain in hcpu_stall.

Test Plan:
1. Reset and idle: hold reset=0 for 2 cycles, then release with instr_valid=0 for 3 cycles → all outputs 0, pc stays 0, instr_ack=0.
2. Register ops: 0x0005 then 0xEC10 (D=A), mem_ready=1 → instr_ack each cycle, D=5, pc=2, readM=writeM=0.
3. Write with wait: A=0x0010, D=5, issue 0xE308 (M=D), mem_ready low 2 cycles → writeM high exactly 3 cycles, outM=5, addressM=0x0010, next instruction not acked until the cycle after mem_ready.
4. Read-modify-write: A=0x0020, 0xFDC8 (M=M+1), inM=0x7FFF, mem_ready after 1 wait → readM 2 cycles, then writeM with outM=0x8000 at addressM=0x0020.
5. Jumps and wrap: D=0xFFFF, A=0x0020, 0xE304 (D;JLT) → pc=0x0020; with D=0 → pc+1. A-instruction at pc=0x7FFF → pc=0x0000.
6. Reset mid-write and WIDTH=32: assert reset while in WR → writeM drops asynchronously, pc=0. Separately, WIDTH=32: 0xEE90 (D=-1) gives D=0xFFFFFFFF, then 0xE304 jumps.
